// File: rtl/ball_renderer.sv
// Rectangular ball sprite: draws the ball against the VGA pixel stream and
// bounces it off all four screen edges, moving once every FRAME_DIV frames.
module ball_renderer #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int BALL_W    = 8,
  parameter int BALL_H    = 8,
  parameter int X_INIT    = 260,
  parameter int Y_INIT    = 300,
  parameter int STEP_X    = 1,
  parameter int STEP_Y    = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic           clk_in,
  input  logic           i_rst,
  input  logic           i_enable,
  input  logic           o_active,
  input  logic [X_W-1:0] o_x,
  input  logic [Y_W-1:0] o_y,
  output logic           color,
  output logic [X_W-1:0] ball_x,
  output logic [Y_W-1:0] ball_y,
  output logic           bounce
);

  localparam logic [X_W:0] XMAX    = (X_W+1)'(H_RES - BALL_W);
  localparam logic [Y_W:0] YMAX    = (Y_W+1)'(V_RES - BALL_H);
  localparam logic [X_W:0] STEP_XW = (X_W+1)'(STEP_X);
  localparam logic [Y_W:0] STEP_YW = (Y_W+1)'(STEP_Y);
  localparam int           FC_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic {S_HOLD, S_MOVE} state_t;

  state_t          state, state_nxt;
  logic            fe, fe_d, fe_rise, fc_last, move_go;
  logic [FC_W-1:0] fcnt;
  logic            dir_x, dir_y;
  logic [X_W:0]    nx;
  logic [Y_W:0]    ny;
  logic            hit;

  // Returns {new_dir, new_pos}; one extra bit of headroom keeps the sum from wrapping.
  function automatic logic [X_W:0] next_x(input logic [X_W-1:0] pos, input logic dir);
    logic [X_W:0] p, q;
    p = {1'b0, pos};
    if (dir) begin
      q = p + STEP_XW;
      if (q >= XMAX) return {1'b0, X_W'(XMAX)};
      return {1'b1, X_W'(q)};
    end
    if (p <= STEP_XW) return {1'b1, {X_W{1'b0}}};
    q = p - STEP_XW;
    return {1'b0, X_W'(q)};
  endfunction

  function automatic logic [Y_W:0] next_y(input logic [Y_W-1:0] pos, input logic dir);
    logic [Y_W:0] p, q;
    p = {1'b0, pos};
    if (dir) begin
      q = p + STEP_YW;
      if (q >= YMAX) return {1'b0, Y_W'(YMAX)};
      return {1'b1, Y_W'(q)};
    end
    if (p <= STEP_YW) return {1'b1, {Y_W{1'b0}}};
    q = p - STEP_YW;
    return {1'b0, Y_W'(q)};
  endfunction

  // Frame end is edge-detected so a held last pixel still counts once.
  assign fe      = (o_x == X_W'(H_RES - 1)) && (o_y == Y_W'(V_RES - 1));
  assign fe_rise = fe && !fe_d;
  assign fc_last = (fcnt == FC_W'(FRAME_DIV - 1));
  assign move_go = fe_rise && i_enable && fc_last;
  assign nx      = next_x(ball_x, dir_x);
  assign ny      = next_y(ball_y, dir_y);

  always_ff @(posedge clk_in) begin
    if (i_rst) state <= S_HOLD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HOLD:  if (move_go) state_nxt = S_MOVE;
      S_MOVE:  state_nxt = S_HOLD;
      default: state_nxt = S_HOLD;
    endcase
  end

  always_comb begin
    logic [X_W:0] px, x_lo, x_hi;
    logic [Y_W:0] py, y_lo, y_hi;
    px   = {1'b0, o_x};
    py   = {1'b0, o_y};
    x_lo = {1'b0, ball_x};
    y_lo = {1'b0, ball_y};
    x_hi = x_lo + (X_W+1)'(BALL_W - 1);
    y_hi = y_lo + (Y_W+1)'(BALL_H - 1);
    hit  = 1'b0;
    if (o_active && (px >= x_lo) && (px <= x_hi) && (py >= y_lo) && (py <= y_hi))
      hit = 1'b1;
  end

  // Stage boundary: registered colour, frame-edge history, motion state.
  always_ff @(posedge clk_in) begin
    if (i_rst) begin
      fe_d   <= 1'b0;
      fcnt   <= '0;
      dir_x  <= 1'b1;
      dir_y  <= 1'b1;
      ball_x <= X_W'(X_INIT);
      ball_y <= Y_W'(Y_INIT);
      color  <= 1'b0;
      bounce <= 1'b0;
    end else begin
      fe_d   <= fe;
      color  <= hit;
      bounce <= 1'b0;
      if (fe_rise && i_enable)
        fcnt <= fc_last ? '0 : fcnt + FC_W'(1);
      if (state == S_MOVE) begin
        dir_x  <= nx[X_W];
        ball_x <= nx[X_W-1:0];
        dir_y  <= ny[Y_W];
        ball_y <= ny[Y_W-1:0];
        bounce <= (nx[X_W] != dir_x) || (ny[Y_W] != dir_y);
      end
    end
  end

endmodule

// File: tb/tb_ball_renderer.sv
// Bench for ball_renderer: five instances with different geometry share one
// pixel stream; colour goes through a scoreboard, motion is checked per frame.
module tb_ball_renderer;

  logic       clk_in = 1'b0;
  logic       i_rst = 1'b1;
  logic       en = 1'b1;
  logic       o_active = 1'b0;
  logic [9:0] o_x = '0;
  logic [8:0] o_y = '0;

  logic       color0, color1, color2, color3, color4;
  logic [9:0] bx0, bx1, bx2, bx3, bx4;
  logic [8:0] by0, by1, by2, by3, by4;
  logic       bn0, bn1, bn2, bn3, bn4;

  int n_chk = 0;
  int n_err = 0;
  int nb0 = 0, nb1 = 0, nb2 = 0;

  always #5 clk_in = ~clk_in;

  ball_renderer dut0 (.clk_in(clk_in), .i_rst(i_rst), .i_enable(en), .o_active(o_active),
    .o_x(o_x), .o_y(o_y), .color(color0), .ball_x(bx0), .ball_y(by0), .bounce(bn0));
  ball_renderer #(.X_INIT(630), .STEP_X(4)) dut1 (.clk_in(clk_in), .i_rst(i_rst),
    .i_enable(en), .o_active(o_active), .o_x(o_x), .o_y(o_y), .color(color1),
    .ball_x(bx1), .ball_y(by1), .bounce(bn1));
  ball_renderer #(.X_INIT(631), .Y_INIT(471)) dut2 (.clk_in(clk_in), .i_rst(i_rst),
    .i_enable(en), .o_active(o_active), .o_x(o_x), .o_y(o_y), .color(color2),
    .ball_x(bx2), .ball_y(by2), .bounce(bn2));
  ball_renderer #(.FRAME_DIV(3)) dut3 (.clk_in(clk_in), .i_rst(i_rst), .i_enable(en),
    .o_active(o_active), .o_x(o_x), .o_y(o_y), .color(color3), .ball_x(bx3),
    .ball_y(by3), .bounce(bn3));
  ball_renderer #(.X_INIT(632), .Y_INIT(472)) dut4 (.clk_in(clk_in), .i_rst(i_rst),
    .i_enable(1'b0), .o_active(o_active), .o_x(o_x), .o_y(o_y), .color(color4),
    .ball_x(bx4), .ball_y(by4), .bounce(bn4));

  always @(negedge clk_in) begin
    if (bn0) nb0++;
    if (bn1) nb1++;
    if (bn2) nb2++;
  end

  typedef struct {
    logic e0;
    logic e4;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int   x;
    int   y;
    logic act;
    logic e0;
    logic e4;
  } vec_t;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic a, input logic e0, input logic e4);
    exp_t e;
    o_x = 10'(x);
    o_y = 9'(y);
    o_active = a;
    e.e0 = e0;
    e.e4 = e4;
    sb.push_back(e);
    step();
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk($sformatf("color0@(%0d,%0d)", x, y), 32'(color0), int'(e.e0));
      chk($sformatf("color4@(%0d,%0d)", x, y), 32'(color4), int'(e.e4));
    end
  endtask

  task automatic frame();
    o_x = 10'd639;
    o_y = 9'd479;
    o_active = 1'b0;
    step();
    o_x = '0;
    o_y = '0;
    step();
    step();
  endtask

  vec_t vecs[13];
  int   exp3[7];
  int   nx0, ny0;

  initial begin
    vecs[0]  = '{260, 300, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{267, 307, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{268, 300, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{260, 308, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{259, 300, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{260, 299, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{263, 303, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{264, 304, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{632, 472, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{639, 478, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{631, 472, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{632, 471, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{635, 475, 1'b0, 1'b0, 1'b0};
    exp3 = '{260, 260, 261, 261, 261, 262, 262};

    // Reset state
    step();
    step();
    i_rst = 1'b0;
    chk("rst_color0", 32'(color0), 0);
    chk("rst_bounce0", 32'(bn0), 0);
    chk("rst_ball_x0", 32'(bx0), 260);
    chk("rst_ball_y0", 32'(by0), 300);
    chk("rst_ball_x1", 32'(bx1), 630);

    // Hit test over the ball boundaries
    foreach (vecs[i]) pix(vecs[i].x, vecs[i].y, vecs[i].act, vecs[i].e0, vecs[i].e4);

    // Seven frames: default motion, edge bounces, frame division
    nx0 = 260;
    ny0 = 300;
    for (int f = 0; f < 7; f++) begin
      frame();
      nx0++;
      ny0++;
      chk($sformatf("ball_x0_f%0d", f + 1), 32'(bx0), nx0);
      chk($sformatf("ball_y0_f%0d", f + 1), 32'(by0), ny0);
      chk($sformatf("ball_x3_f%0d", f + 1), 32'(bx3), exp3[f]);
      if (f == 0) begin
        chk("edge_ball_x1_f1", 32'(bx1), 632);
        chk("edge_bounce_cnt1_f1", 32'(nb1), 1);
        chk("corner_ball_x2_f1", 32'(bx2), 632);
        chk("corner_ball_y2_f1", 32'(by2), 472);
        chk("corner_bounce_cnt2_f1", 32'(nb2), 1);
      end
      if (f == 1) begin
        chk("edge_ball_x1_f2", 32'(bx1), 628);
        chk("edge_bounce_cnt1_f2", 32'(nb1), 1);
        chk("corner_ball_x2_f2", 32'(bx2), 631);
        chk("corner_ball_y2_f2", 32'(by2), 471);
        chk("corner_bounce_cnt2_f2", 32'(nb2), 1);
      end
    end
    chk("no_bounce_cnt0", 32'(nb0), 0);

    // Frozen motion while disabled, frame counter held
    en = 1'b0;
    for (int f = 0; f < 4; f++) frame();
    chk("frozen_ball_x0", 32'(bx0), 267);
    chk("frozen_ball_x3", 32'(bx3), 262);
    en = 1'b1;
    frame();
    chk("resume_ball_x0_a", 32'(bx0), 268);
    chk("resume_ball_x3_a", 32'(bx3), 262);
    frame();
    chk("resume_ball_x0_b", 32'(bx0), 269);
    chk("resume_ball_x3_b", 32'(bx3), 263);

    // Held frame-end pixel: one update only, never coloured while inactive
    for (int k = 0; k < 5; k++) pix(639, 479, 1'b0, 1'b0, 1'b0);
    o_x = '0;
    o_y = '0;
    step();
    step();
    chk("held_ball_x0", 32'(bx0), 270);
    chk("held_ball_y0", 32'(by0), 310);

    // Reset landing on the S_MOVE cycle
    o_x = 10'd639;
    o_y = 9'd479;
    o_active = 1'b0;
    step();
    i_rst = 1'b1;
    o_x = 10'd270;
    o_y = 9'd310;
    o_active = 1'b1;
    step();
    i_rst = 1'b0;
    chk("midrst_ball_x0", 32'(bx0), 260);
    chk("midrst_ball_y0", 32'(by0), 300);
    chk("midrst_color0", 32'(color0), 0);
    chk("midrst_bounce0", 32'(bn0), 0);
    chk("midrst_ball_x3", 32'(bx3), 260);
    o_x = '0;
    o_y = '0;
    o_active = 1'b0;
    step();
    frame();
    chk("after_rst_ball_x0", 32'(bx0), 261);
    chk("after_rst_ball_y0", 32'(by0), 301);
    chk("after_rst_ball_x3", 32'(bx3), 260);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
